// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan path: pin polarities, default
// scan geometry, segment bit order and the per-slot state encoding.
package seg7_pkg;
  localparam logic ANODE_OFF = 1'b1;
  localparam logic ANODE_ON  = 1'b0;
  localparam logic DP_OFF    = 1'b1;

  localparam int DEF_NDIG = 4;
  localparam int DEF_DIV  = 100000;
  localparam int DEF_GAP  = 4;

  // Segment vector order {a,b,c,d,e,f,g}: a is the MSB, g the LSB, 0 = lit
  localparam int   SEG_A_BIT = 6;
  localparam int   SEG_B_BIT = 5;
  localparam int   SEG_C_BIT = 4;
  localparam int   SEG_D_BIT = 3;
  localparam int   SEG_E_BIT = 2;
  localparam int   SEG_F_BIT = 1;
  localparam int   SEG_G_BIT = 0;
  localparam logic SEG_ON    = 1'b0;

  typedef enum logic {ST_GUARD = 1'b0, ST_DRIVE = 1'b1} slot_state_t;
endpackage

// File: rtl/scan_tick_gen.sv
// Slot/digit timebase: cnt counts cycles within a slot, idx selects the digit.
// in_guard describes the upcoming cycle so the top can register its outputs.
module scan_tick_gen import seg7_pkg::*; #(
  parameter int NDIG = DEF_NDIG,
  parameter int DIV  = DEF_DIV,
  parameter int GAP  = DEF_GAP,
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1,
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx_nxt,
  output logic          in_guard,
  output logic          slot_wrap,
  output logic          frame_wrap,
  output logic          frame_wrap_nxt
);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx;
  slot_state_t   state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      state <= ST_GUARD;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    slot_wrap  = (cnt == CNT_LAST);
    frame_wrap = slot_wrap && (idx == IDX_LAST);
    cnt_nxt    = slot_wrap ? '0 : cnt + 1'b1;
    idx_nxt    = idx;
    if (slot_wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    state_nxt = state;
    case (state)
      ST_GUARD: if (cnt == GUARD_END) state_nxt = ST_DRIVE;
      ST_DRIVE: if (slot_wrap)        state_nxt = ST_GUARD;
      default:                        state_nxt = ST_GUARD;
    endcase

    in_guard       = (state_nxt == ST_GUARD);
    frame_wrap_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode display scanner: stages loads, commits them at
// frame boundaries and drives registered anode/decimal-point/nibble outputs.
module seg7_scan_ctrl import seg7_pkg::*; #(
  parameter int NDIG        = DEF_NDIG,
  parameter int DIV         = DEF_DIV,
  parameter int GAP         = DEF_GAP,
  parameter bit LZ_SUPPRESS = 1'b1,
  localparam int IW         = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] value_in,
  input  logic [NDIG-1:0]   blank_in,
  input  logic [NDIG-1:0]   dp_in,
  output logic [NDIG-1:0]   an,
  output logic [3:0]        digit_bin,
  output logic              dp_n,
  output logic              pending,
  output logic              frame_done
);
  typedef struct packed {
    logic [NDIG-1:0][3:0] value;
    logic [NDIG-1:0]      blank;
    logic [NDIG-1:0]      dp;
  } disp_t;

  logic [IW-1:0]   idx_nxt;
  logic            in_guard, slot_wrap, frame_wrap, frame_wrap_nxt;
  disp_t           in_rec, staged, comm, comm_nxt;
  logic [NDIG-1:0] dark, an_nxt;
  logic            dp_n_nxt, upper_zero;

  scan_tick_gen #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP)) u_tick (
    .clk            (clk),
    .rst            (rst),
    .idx_nxt        (idx_nxt),
    .in_guard       (in_guard),
    .slot_wrap      (slot_wrap),
    .frame_wrap     (frame_wrap),
    .frame_wrap_nxt (frame_wrap_nxt)
  );

  // A load landing on the wrap with nothing pending goes straight to display.
  always_comb begin
    in_rec.value = value_in;
    in_rec.blank = blank_in;
    in_rec.dp    = dp_in;
    comm_nxt     = comm;
    if (frame_wrap) begin
      if (pending)   comm_nxt = staged;
      else if (load) comm_nxt = in_rec;
    end
  end

  always_comb begin
    upper_zero = 1'b1;
    dark       = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (comm_nxt.value[i] == 4'h0);
      dark[i]    = comm_nxt.blank[i] || (LZ_SUPPRESS && (i > 0) && upper_zero);
    end
  end

  always_comb begin
    an_nxt   = {NDIG{ANODE_OFF}};
    dp_n_nxt = DP_OFF;
    if (!in_guard && !dark[idx_nxt]) begin
      an_nxt[idx_nxt] = ANODE_ON;
      dp_n_nxt        = ~comm_nxt.dp[idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= {NDIG{ANODE_OFF}};
      digit_bin  <= 4'h0;
      dp_n       <= DP_OFF;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      staged     <= '0;
      comm.value <= '0;
      comm.blank <= '1;
      comm.dp    <= '0;
    end else begin
      an         <= an_nxt;
      dp_n       <= dp_n_nxt;
      frame_done <= frame_wrap_nxt;
      comm       <= comm_nxt;
      if (slot_wrap) digit_bin <= comm_nxt.value[idx_nxt];
      if (load)      staged    <= in_rec;
      if (frame_wrap)  pending <= pending && load;
      else if (load)   pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG=4, DIV=8, GAP=2; one instance
// without and one with leading-zero suppression, fed the same stimulus.
module tb_seg7_scan_ctrl;
  localparam int NDIG = 4;
  localparam int DIV  = 8;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an0, an1, db0, db1;
  logic        dpn0, dpn1, pend0, pend1, fd0, fd1;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP), .LZ_SUPPRESS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .blank_in(blank_in),
    .dp_in(dp_in), .an(an0), .digit_bin(db0), .dp_n(dpn0), .pending(pend0),
    .frame_done(fd0));

  seg7_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP), .LZ_SUPPRESS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .blank_in(blank_in),
    .dp_in(dp_in), .an(an1), .digit_bin(db1), .dp_n(dpn1), .pending(pend1),
    .frame_done(fd1));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " an0"}, 16'(an0), 16'hF);
    chk({tag, " an1"}, 16'(an1), 16'hF);
    chk({tag, " db0"}, 16'(db0), 16'h0);
    chk({tag, " dpn0"}, 16'(dpn0), 16'h1);
    chk({tag, " pend0"}, 16'(pend0), 16'h0);
    chk({tag, " pend1"}, 16'(pend1), 16'h0);
    chk({tag, " fd0"}, 16'(fd0), 16'h0);
  endtask

  // Starts at frame position 0; frame_done expected every 32nd cycle.
  task automatic run_dark(input int n);
    for (int k = 1; k <= n; k++) begin
      step();
      chk($sformatf("dark an0 k%0d", k), 16'(an0), 16'hF);
      chk($sformatf("dark an1 k%0d", k), 16'(an1), 16'hF);
      chk($sformatf("dark dpn k%0d", k), 16'({dpn1, dpn0}), 16'h3);
      chk($sformatf("dark pend k%0d", k), 16'({pend1, pend0}), 16'h0);
      chk($sformatf("dark fd0 k%0d", k), 16'(fd0), 16'((k % 32) == 31));
      chk($sformatf("dark fd1 k%0d", k), 16'(fd1), 16'((k % 32) == 31));
    end
  endtask

  task automatic wait_frame();
    int k = 0;
    while (fd0 !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk("wait_frame", 16'(fd0), 16'h1);
    step();
  endtask

  // Checks one whole frame from position 0; optional loads at positions p1/p2.
  task automatic check_frame(input logic [15:0] dig, input logic [3:0] lit0,
                             input logic [3:0] lit1, input logic [3:0] dpm,
                             input int p1, input logic [15:0] v1, input logic [3:0] b1,
                             input logic [3:0] d1,
                             input int p2, input logic [15:0] v2, input logic [3:0] b2,
                             input logic [3:0] d2);
    logic [3:0] one, ea0, ea1;
    logic       ed0, ed1;
    for (int p = 0; p < 32; p++) begin
      int s = p / 8;
      int c = p % 8;
      one = 4'b0001 << s;
      ea0 = (c >= GAP && lit0[s]) ? ~one : 4'hF;
      ea1 = (c >= GAP && lit1[s]) ? ~one : 4'hF;
      ed0 = (c >= GAP && lit0[s]) ? ~dpm[s] : 1'b1;
      ed1 = (c >= GAP && lit1[s]) ? ~dpm[s] : 1'b1;
      chk($sformatf("an0 %h p%0d", dig, p), 16'(an0), 16'(ea0));
      chk($sformatf("an1 %h p%0d", dig, p), 16'(an1), 16'(ea1));
      chk($sformatf("db0 %h p%0d", dig, p), 16'(db0), 16'(dig[s*4 +: 4]));
      chk($sformatf("db1 %h p%0d", dig, p), 16'(db1), 16'(dig[s*4 +: 4]));
      chk($sformatf("dpn0 %h p%0d", dig, p), 16'(dpn0), 16'(ed0));
      chk($sformatf("dpn1 %h p%0d", dig, p), 16'(dpn1), 16'(ed1));
      chk($sformatf("fd %h p%0d", dig, p), 16'({fd1, fd0}), (p == 31) ? 16'h3 : 16'h0);
      load = 1'b0;
      if (p == p1) begin
        load = 1'b1; value_in = v1; blank_in = b1; dp_in = d1;
      end else if (p == p2) begin
        load = 1'b1; value_in = v2; blank_in = b2; dp_in = d2;
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    load = 1'b1; value_in = v; blank_in = b; dp_in = d;
    step();
    load = 1'b0;
  endtask

  initial begin
    // Reset, then two dark frames
    rst = 1'b1;
    repeat (3) step();
    chk_reset_outs("reset");
    rst = 1'b0;
    run_dark(64);

    // Basic load: 12A0, dp on digit 2
    do_load(16'h12A0, 4'h0, 4'b0100);
    chk("basic pend0", 16'(pend0), 16'h1);
    chk("basic pend1", 16'(pend1), 16'h1);
    wait_frame();
    chk("basic commit pend", 16'({pend1, pend0}), 16'h0);
    check_frame(16'h12A0, 4'b1111, 4'b1111, 4'b0100,
                -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

    // Leading-zero suppression
    do_load(16'h0050, 4'h0, 4'h0);
    wait_frame();
    check_frame(16'h0050, 4'b1111, 4'b0011, 4'h0,
                -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    do_load(16'h0000, 4'h0, 4'h0);
    wait_frame();
    // All-zero frame; meanwhile 1111 then 2222 are loaded (last wins)
    check_frame(16'h0000, 4'b1111, 4'b0001, 4'h0,
                5, 16'h1111, 4'h0, 4'h0, 20, 16'h2222, 4'h0, 4'h0);
    chk("lastwins pend", 16'({pend1, pend0}), 16'h0);

    // 2222 shown; AAAA staged mid-frame, BBBB loaded in the wrap cycle
    check_frame(16'h2222, 4'b1111, 4'b1111, 4'h0,
                3, 16'hAAAA, 4'h0, 4'h0, 31, 16'hBBBB, 4'b0010, 4'b1011);
    chk("wrapload pend kept", 16'({pend1, pend0}), 16'h3);
    check_frame(16'hAAAA, 4'b1111, 4'b1111, 4'h0,
                -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    chk("wrapload pend clr", 16'({pend1, pend0}), 16'h0);
    // BBBB with digit 1 blanked (its dp must stay dark); 0C00 loaded on wrap, nothing pending
    check_frame(16'hBBBB, 4'b1101, 4'b1101, 4'b1011,
                31, 16'h0C00, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    chk("bypass pend", 16'({pend1, pend0}), 16'h0);

    // Mid-slot reset while 0C00 is displayed and 3333 is staged
    do_load(16'h3333, 4'h0, 4'h0);
    chk("pre-rst pend", 16'({pend1, pend0}), 16'h3);
    repeat (20) step();
    chk("pre-rst an0", 16'(an0), 16'hB);
    chk("pre-rst an1", 16'(an1), 16'hB);
    chk("pre-rst db0", 16'(db0), 16'hC);
    rst = 1'b1;
    load = 1'b1; value_in = 16'h4444;
    step();
    rst = 1'b0;
    load = 1'b0;
    chk_reset_outs("midrst");
    run_dark(64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scan controller for the board's common-anode 7-segment display. It latches a multi-digit hex value from the datapath and commits it tear-free at frame boundaries. Each scan slot selects one digit nibble to drive the shared 4-bit hex-to-segment decoder, and asserts the matching anode after a ghosting guard gap. It sits between the system logic and the display pins; the decoder's 7-bit output goes straight to the segment pins.

## Interface
- `NDIG`, 4, number of digits scanned (≥2)
- `DIV`, 100000, clock cycles per digit slot (≥ GAP+2)
- `GAP`, 4, leading cycles of each slot with all anodes off (≥1)
- `LZ_SUPPRESS`, 1, blank leading zero digits when 1
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `load`  in  1  one-cycle strobe: stage `value_in`, `blank_in`, `dp_in`
- `value_in`  in  4*NDIG  hex digits, digit 0 in bits [3:0]
- `blank_in`  in  NDIG  per-digit force-blank, 1 = dark
- `dp_in`  in  NDIG  per-digit decimal point, 1 = lit
- `an`  out  NDIG  anodes, active-low (0 = digit on)
- `digit_bin`  out  4  nibble to hex decoder
- `dp_n`  out  1  decimal point, active-low
- `pending`  out  1  staged value not yet committed
- `frame_done`  out  1  one-cycle pulse on last cycle of each frame

## Operation
- Registers: staged {value, blank, dp}; committed {value, blank, dp}; slot counter `cnt` (width clog2(DIV)); digit index `idx` (width max(1, clog2(NDIG))).
- Per-slot FSM: GUARD (cnt 0..GAP-1) → DRIVE (cnt GAP..DIV-1) → GUARD of the next slot. `cnt` wraps DIV-1→0. `idx` increments at that wrap and wraps NDIG-1→0.
- Wrap cycle: `idx`==NDIG-1 and `cnt`==DIV-1. `frame_done`=1 in that cycle. If `pending`, committed ← staged at its closing edge and `pending` clears.
- `load`: staged ← inputs and `pending` ← 1. Last load before the commit wins; earlier staged data is discarded.
- `load` in the wrap cycle with `pending`=1: the old staged value commits. The new value becomes staged and `pending` stays 1.
- Digit `i` is dark when any of the following holds:
  - committed blank[i]=1;
  - LZ_SUPPRESS=1, i>0, and committed nibbles i..NDIG-1 are all zero.
- Digit 0 is never zero-suppressed.
- GUARD: `an` all 1, `dp_n`=1.
- DRIVE: `an[idx]`=0 unless digit `idx` is dark; all other bits 1. `dp_n` = ~committed dp[idx], but 1 when the digit is dark.
- `digit_bin` = committed nibble[idx] for the whole slot, dark or not.

## Timing
- `an`, `dp_n`, `digit_bin` and `frame_done` are registered, with no combinational path from inputs. In the cycle where the registered `cnt`/`idx` hold a value, the outputs show the decode of that value; next-state logic feeds the output flops.
- Reset values: `an`=all 1, `digit_bin`=0, `dp_n`=1, `pending`=0, `frame_done`=0, `cnt`=0, `idx`=0.
- Reset values, data registers: committed value=0, committed blank=all 1 (display dark until the first commit), staged cleared.
- `rst` mid-slot: state and outputs return to reset values on the next edge. Any staged load is lost.
- `load` with `rst` in the same cycle: reset wins.
- Latency from load to display: at most NDIG*DIV+1 cycles, at least 1 cycle (load in the wrap cycle).
- Frame period: NDIG*DIV cycles exactly. Digit `idx` is on for DIV-GAP cycles per frame.

## Structure
- Shared package `seg7_pkg`:
  - `ANODE_OFF`/`ANODE_ON` and `DP_OFF` polarity constants;
  - default NDIG/DIV/GAP localparams;
  - the segment-bit order constant (A = MSB, G = LSB, active-low).
- Sub-module `scan_tick_gen` holds `cnt`/`idx`. It emits `in_guard`, `slot_wrap`, `frame_wrap`.
- The top holds the staging/commit registers, blanking logic and output flops.
- The hex decoder is instantiated beside this block, not inside it.

## Test plan
Test parameters: NDIG=4, DIV=8, GAP=2.
- Reset: hold `rst` for 3 cycles, then run 2 frames with no load → `an`=4'b1111 throughout, `dp_n`=1, `pending`=0, `frame_done` pulses every 32 cycles.
- Basic load, LZ_SUPPRESS=0: `load` with value 16'h12A0, blank 0, dp 4'b0100 → `pending`=1 until the next wrap. The following frame then shows:
  - slot 0: `digit_bin`=0 with `an`=1110;
  - slot 1: `digit_bin`=A with `an`=1101;
  - slot 2: `digit_bin`=2 with `an`=1011 and `dp_n`=0;
  - slot 3: `digit_bin`=1 with `an`=0111;
  - in every slot, `an` is driven in cnt 2..7 only.
- Zero suppression, LZ_SUPPRESS=1: value 16'h0050 → slots 3 and 2 keep `an`=1111, slot 1 shows 5, slot 0 shows 0. Value 16'h0000 → only digit 0 is lit.
- Last-wins: loads of 16'h1111 then 16'h2222 in the same frame → 1111 is never displayed, 2222 is displayed from the next frame.
- Load on wrap: stage 16'hAAAA, then `load` 16'hBBBB exactly in the `frame_done` cycle → AAAA is shown for one frame with `pending`=1, then BBBB is shown and `pending`=0.
- Mid-slot reset: assert `rst` at slot 2, cnt=5, while displaying → next cycle `an`=1111, `idx`=0, `cnt`=0, `pending`=0, and the display stays dark until a new load commits.
